adc_frame_fifo: RTL and testbench
=================================

Name: adc_frame_fifo

Overview:
Parametrised single-clock capture buffer for ADC samples.
- An arm edge on wr_start starts capture of exactly FRAME_LEN valid samples into an internal FIFO.
- The block then drains that frame on a valid/ready stream toward the PS/DDR path, then returns to idle.
- Successor to the fixed 12-to-16-bit, 1024-deep capture FIFO: width, depth and frame length are parametrised; it adds backpressure, a last-beat marker, overflow accounting and abort.

Parameters:
DIN_W, 12, ADC sample width (1..DOUT_W).
DOUT_W, 16, output word width; sample zero-extended into LSBs.
DEPTH, 1024, FIFO depth in words; power of 2, >=4.
FRAME_LEN, 1024, samples per frame; 1..DEPTH.
AF_THRESH, DEPTH-16, almost_full asserted when level >= AF_THRESH.

Ports:
clk_100m  in  1  sole clock, all logic rising edge.
rstn_i  in  1  asynchronous active-low reset.
wr_start  in  1  level; rising edge arms a capture.
abort  in  1  synchronous flush to IDLE.
din_valid  in  1  qualifies din this cycle.
din  in  DIN_W  ADC sample.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accepts.
m_data  out  DOUT_W  output word.
m_last  out  1  marks final word of frame.
full  out  1  level == DEPTH.
empty  out  1  level == 0.
almost_full  out  1  level >= AF_THRESH.
level  out  $clog2(DEPTH)+1  words stored.
busy  out  1  state != IDLE.
frame_done  out  1  one-cycle pulse after last beat.
ovf_cnt  out  16  dropped samples, saturating.

Behaviour:
Reset (rstn_i=0, async):
- State IDLE; pointers and counters 0.
- All outputs 0 except empty=1.
- wr_start edge-detect register resets to 1, so wr_start held high through reset does not arm.

States:
- IDLE:
  - wr_start 0->1 (registered edge) -> CAPTURE; frame write counter cleared.
  - din_valid ignored in IDLE, not counted as overflow.
- CAPTURE:
  - Each cycle with din_valid=1 writes {zeros, din} at wr_ptr, and wr_ptr, level and write counter each increment by 1.
  - On the write that makes the counter == FRAME_LEN -> DRAIN next cycle.
  - full cannot occur since FRAME_LEN <= DEPTH; if full anyway, the sample is dropped and ovf_cnt increments.
- DRAIN:
  - Output register loads mem[rd_ptr]; m_valid rises 1 cycle after DRAIN entry and stays high while level > 0.
  - Transfer = m_valid && m_ready.
  - m_data and m_last are held stable while m_valid && !m_ready.
  - m_last=1 on beat number FRAME_LEN (count from 1).
  - Transfer with m_last -> IDLE; frame_done=1 for exactly the next cycle; m_valid=0 that cycle.
  - din_valid=1 in DRAIN: sample dropped, ovf_cnt += 1 (saturates at 0xFFFF).

General rules:
- Throughput: one write per cycle in CAPTURE; one read per cycle in DRAIN with m_ready held high.
- wr_start edges in CAPTURE or DRAIN are ignored, not queued.
- Pointers wrap modulo DEPTH; level is the exact count, 0..DEPTH.
- abort=1 (any state): next cycle IDLE, pointers, level and output register cleared, m_valid=0, no frame_done. ovf_cnt is retained. abort has priority over a simultaneous wr_start edge, write or read.
- Reset asserted mid-frame: immediate return to reset values; no partial frame is output after release.
- ovf_cnt clears only on reset.

Optional Feature:
TEST_PATTERN_EN:
- Defined: an extra input test_mode (1 bit) selects the data source. When test_mode=1, the written word is an internal DIN_W-bit ramp instead of din. The ramp starts at 0 on each CAPTURE entry, increments per accepted write and wraps at 2^DIN_W.
- Undefined: no test_mode port; din is always written.

Test Plan:
1. DEPTH=8, FRAME_LEN=8, din 0x001..0x008 with din_valid=1 and m_ready=1 -> m_data 0x0001..0x0008 in order, m_last on 0x0008, frame_done 1 cycle later, ovf_cnt=0.
2. Same frame, m_ready toggling 1,0,0,1 -> no loss or duplication; m_data held stable during stalls; level decrements only on transfers.
3. DIN_W=12, din=0xFFF -> m_data=0x0FFF (zero-extend); with FRAME_LEN=4, AF_THRESH=3, almost_full asserts at level 3.
4. 5 samples sent while in DRAIN -> ovf_cnt=5, frame content unchanged; ovf_cnt preset near 0xFFFF saturates at 0xFFFF.
5. abort after 3 of 8 samples -> busy=0 next cycle, empty=1, m_valid stays 0, no frame_done; a new wr_start edge captures a clean frame.
6. wr_start held 1 through reset release -> no capture; rstn_i low mid-DRAIN -> all outputs reset immediately; with TEST_PATTERN_EN, test_mode=1 gives ramp 0x000..0x007.

Source files
------------

// File: rtl/adc_frame_fifo.sv
// adc_frame_fifo: single-clock ADC frame capture buffer.
// Arms on a wr_start rising edge, captures FRAME_LEN samples into a FIFO,
// then drains them on a valid/ready stream with a last-beat marker.
// Optional feature macro: TEST_PATTERN_EN (adds test_mode, writes a ramp).
module adc_frame_fifo #(
    parameter int unsigned DIN_W     = 12,
    parameter int unsigned DOUT_W    = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned AF_THRESH = DEPTH - 16
) (
    input  logic                     clk_100m,
    input  logic                     rstn_i,
    input  logic                     wr_start,
    input  logic                     abort,
    input  logic                     din_valid,
    input  logic [DIN_W-1:0]         din,
`ifdef TEST_PATTERN_EN
    input  logic                     test_mode,
`endif
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DOUT_W-1:0]        m_data,
    output logic                     m_last,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              ovf_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DOUT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    wr_cnt, rd_cnt;
    logic [LVL_W-1:0]    level_nxt, unread;
    logic                wr_start_q;
    logic                arm, wr_en, drop, load, xfer, done;
    logic [DOUT_W-1:0]   wr_data;

    // Rising edge of wr_start; the history register resets high so a held level never arms.
    assign arm = wr_start && !wr_start_q;

    // Words in the FIFO that have not yet been moved into the output register.
    assign unread = level - LVL_W'(m_valid);

`ifdef TEST_PATTERN_EN
    logic [DIN_W-1:0] ramp;
    assign wr_data = test_mode ? DOUT_W'(ramp) : DOUT_W'(din);
`else
    assign wr_data = DOUT_W'(din);
`endif

    // State register.
    always_ff @(posedge clk_100m or negedge rstn_i) begin
        if (!rstn_i) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and datapath strobes; abort overrides everything.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        drop      = 1'b0;
        load      = 1'b0;
        xfer      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (din_valid) begin
                    if (full) begin
                        drop = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (wr_cnt == LVL_W'(FRAME_LEN - 1)) state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                drop = din_valid;
                xfer = m_valid && m_ready;
                if (xfer && m_last) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else if ((!m_valid || xfer) && unread != '0) begin
                    load = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            wr_en     = 1'b0;
            drop      = 1'b0;
            load      = 1'b0;
            xfer      = 1'b0;
            done      = 1'b0;
        end
        level_nxt = abort ? '0 : level + LVL_W'(wr_en) - LVL_W'(xfer);
    end

    // Sample storage (no reset; pointers define which words are meaningful).
    always_ff @(posedge clk_100m) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Pointers, counters, output register and status flags.
    always_ff @(posedge clk_100m or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_start_q  <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            frame_done  <= 1'b0;
            level       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            busy        <= 1'b0;
        end else begin
            wr_start_q  <= wr_start;
            frame_done  <= done;
            level       <= level_nxt;
            full        <= (level_nxt == LVL_W'(DEPTH));
            empty       <= (level_nxt == '0);
            almost_full <= (level_nxt >= LVL_W'(AF_THRESH));
            busy        <= (state_nxt != S_IDLE);
            if (abort) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                m_valid <= 1'b0;
                m_data  <= '0;
                m_last  <= 1'b0;
            end else begin
                if (state == S_IDLE && arm) begin
                    wr_cnt <= '0;
                    rd_cnt <= '0;
                end
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    wr_cnt <= wr_cnt + LVL_W'(1);
                end
                if (load) begin
                    m_data  <= mem[rd_ptr];
                    m_last  <= ((rd_cnt + LVL_W'(1)) == LVL_W'(FRAME_LEN));
                    m_valid <= 1'b1;
                    rd_ptr  <= rd_ptr + PTR_W'(1);
                    rd_cnt  <= rd_cnt + LVL_W'(1);
                end else if (xfer) begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end
        end
    end

    // Dropped-sample counter; saturates and clears only on reset.
    always_ff @(posedge clk_100m or negedge rstn_i) begin
        if (!rstn_i)                         ovf_cnt <= '0;
        else if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
    end

`ifdef TEST_PATTERN_EN
    // Test ramp restarts on each capture arm and advances per accepted write.
    always_ff @(posedge clk_100m or negedge rstn_i) begin
        if (!rstn_i)                              ramp <= '0;
        else if (state == S_IDLE && arm && !abort) ramp <= '0;
        else if (wr_en)                            ramp <= ramp + DIN_W'(1);
    end
`endif

endmodule

// File: tb/tb_adc_frame_fifo.sv
// Directed bench for adc_frame_fifo (DEPTH=8, FRAME_LEN=8, AF_THRESH=6).
module tb_adc_frame_fifo;

    localparam int unsigned FL = 8;

    logic        clk_100m = 1'b0;
    logic        rstn_i;
    logic        wr_start, abort, din_valid, m_ready;
    logic [11:0] din;
    logic        m_valid, m_last, full, empty, almost_full, busy, frame_done;
    logic [15:0] m_data, ovf_cnt;
    logic [3:0]  level;
`ifdef TEST_PATTERN_EN
    logic        test_mode;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [11:0] din_vec [FL];
    logic [15:0] exp_vec [FL];

    always #5 clk_100m = ~clk_100m;

    adc_frame_fifo #(
        .DIN_W(12), .DOUT_W(16), .DEPTH(8), .FRAME_LEN(FL), .AF_THRESH(6)
    ) u_dut (
        .clk_100m(clk_100m), .rstn_i(rstn_i), .wr_start(wr_start), .abort(abort),
        .din_valid(din_valid), .din(din),
`ifdef TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .full(full), .empty(empty), .almost_full(almost_full), .level(level),
        .busy(busy), .frame_done(frame_done), .ovf_cnt(ovf_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100m);
        #1;
    endtask

    // Arm and write the din_vec frame, checking level and almost_full per write.
    task automatic capture();
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        check_eq("busy_after_arm", 32'(busy), 32'd1);
        for (int i = 0; i < int'(FL); i++) begin
            din       = din_vec[i];
            din_valid = 1'b1;
            tick();
            check_eq("cap_level", 32'(level), 32'(i + 1));
            check_eq("cap_almost_full", 32'(almost_full), 32'((i + 1) >= 6));
        end
        din_valid = 1'b0;
        check_eq("cap_full", 32'(full), 32'd1);
    endtask

    // Drain one frame against exp_vec; stall_mode applies ready pattern 1,0,0,1.
    task automatic drain_frame(input bit stall_mode);
        int          beat;
        int          cyc;
        logic [15:0] held;
        logic        held_v;
        logic [3:0]  pat;
        beat   = 0;
        cyc    = 0;
        held_v = 1'b0;
        pat    = 4'b1001;
        while (beat < int'(FL) && cyc < 64) begin
            m_ready = stall_mode ? pat[cyc % 4] : 1'b1;
            if (m_valid) begin
                check_eq("drain_level", 32'(level), 32'(int'(FL) - beat));
                if (held_v) check_eq("stall_hold", 32'(m_data), 32'(held));
                if (m_ready) begin
                    check_eq("drain_data", 32'(m_data), 32'(exp_vec[beat]));
                    check_eq("drain_last", 32'(m_last), 32'(beat == int'(FL) - 1));
                    beat++;
                    held_v = 1'b0;
                end else begin
                    held   = m_data;
                    held_v = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check_eq("drain_beats", 32'(beat), 32'(FL));
        check_eq("done_pulse", 32'(frame_done), 32'd1);
        check_eq("done_valid", 32'(m_valid), 32'd0);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_empty", 32'(empty), 32'd1);
        tick();
        check_eq("done_once", 32'(frame_done), 32'd0);
    endtask

    initial begin
        rstn_i    = 1'b0;
        wr_start  = 1'b0;
        abort     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        m_ready   = 1'b0;
`ifdef TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        tick();
        tick();
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_valid", 32'(m_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_ovf", 32'(ovf_cnt), 32'd0);
        rstn_i = 1'b1;
        tick();

        // Basic frame 1..8 with ready held high.
        for (int i = 0; i < int'(FL); i++) begin
            din_vec[i] = 12'(i + 1);
            exp_vec[i] = 16'(i + 1);
        end
        capture();
        drain_frame(1'b0);
        check_eq("ovf_basic", 32'(ovf_cnt), 32'd0);

        // Same frame with backpressure.
        capture();
        drain_frame(1'b1);

        // Zero extension of full-scale and mixed samples.
        din_vec[0] = 12'hFFF; exp_vec[0] = 16'h0FFF;
        din_vec[1] = 12'h800; exp_vec[1] = 16'h0800;
        din_vec[2] = 12'h000; exp_vec[2] = 16'h0000;
        din_vec[3] = 12'hABC; exp_vec[3] = 16'h0ABC;
        din_vec[4] = 12'h555; exp_vec[4] = 16'h0555;
        din_vec[5] = 12'hAAA; exp_vec[5] = 16'h0AAA;
        din_vec[6] = 12'h001; exp_vec[6] = 16'h0001;
        din_vec[7] = 12'hFFE; exp_vec[7] = 16'h0FFE;
        capture();
        drain_frame(1'b0);

        // Samples during DRAIN are dropped and counted; IDLE samples are ignored.
        capture();
        din = 12'h123;
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        din_valid = 1'b0;
        check_eq("ovf_five", 32'(ovf_cnt), 32'd5);
        drain_frame(1'b0);
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        din_valid = 1'b0;
        check_eq("ovf_idle", 32'(ovf_cnt), 32'd5);

        // Abort after three samples, then a clean frame.
        wr_start = 1'b1;
        tick();
        wr_start = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 12'h700 + 12'(i);
            tick();
        end
        din_valid = 1'b0;
        check_eq("pre_abort_level", 32'(level), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_empty", 32'(empty), 32'd1);
        check_eq("abort_level", 32'(level), 32'd0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("abort_valid", 32'(m_valid), 32'd0);
            check_eq("abort_nodone", 32'(frame_done), 32'd0);
            tick();
        end
        m_ready = 1'b0;
        check_eq("abort_ovf_kept", 32'(ovf_cnt), 32'd5);
        capture();
        drain_frame(1'b0);

        // Overflow counter saturation while the drain is stalled.
        capture();
        din_valid = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        din_valid = 1'b0;
        check_eq("ovf_sat", 32'(ovf_cnt), 32'hFFFF);
        drain_frame(1'b0);

`ifdef TEST_PATTERN_EN
        test_mode = 1'b1;
        for (int i = 0; i < int'(FL); i++) begin
            din_vec[i] = 12'hF0F;
            exp_vec[i] = 16'(i);
        end
        capture();
        drain_frame(1'b0);
        test_mode = 1'b0;
`endif

        // wr_start held high across reset must not arm.
        wr_start = 1'b1;
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        tick();
        tick();
        check_eq("held_start_busy", 32'(busy), 32'd0);
        wr_start = 1'b0;
        tick();

        // Reset mid-DRAIN clears outputs immediately; nothing resumes after release.
        for (int i = 0; i < int'(FL); i++) begin
            din_vec[i] = 12'h0A0 + 12'(i);
            exp_vec[i] = 16'h00A0 + 16'(i);
        end
        capture();
        tick();
        check_eq("pre_rst_valid", 32'(m_valid), 32'd1);
        rstn_i = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(m_valid), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_empty", 32'(empty), 32'd1);
        check_eq("rst_mid_level", 32'(level), 32'd0);
        check_eq("rst_mid_ovf", 32'(ovf_cnt), 32'd0);
        tick();
        rstn_i = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("post_rst_valid", 32'(m_valid), 32'd0);
        end
        m_ready = 1'b0;
        capture();
        drain_frame(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
